// File: rtl/adc_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_pkg
// Description : Shared widths, the result record and the rounding helper
//               used by the ADC channel averager and its result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_avg_pkg;

  localparam int ADC_CH_W     = 5;
  localparam int ADC_DATA_W   = 12;
  localparam int DROP_CNT_W   = 8;
  localparam int MAX_LOG2_AVG = 8;
  // Widest possible accumulator total (12 data bits + 8 averaging bits).
  localparam int TOTAL_W      = ADC_DATA_W + MAX_LOG2_AVG;

  typedef struct packed {
    logic [ADC_CH_W-1:0]   channel;
    logic [ADC_DATA_W-1:0] data;
  } adc_result_t;

  // Round-half-up average: (total + 2^(log2n-1)) >> log2n, evaluated one bit
  // wider than the total so the bias cannot wrap, then truncated to 12 bits.
  function automatic logic [ADC_DATA_W-1:0] round_avg(
    input logic [TOTAL_W-1:0] total,
    input int unsigned        log2n
  );
    logic [TOTAL_W:0] w_biased;
    logic [TOTAL_W:0] w_shifted;
    w_biased = {1'b0, total};
    if (log2n != 0) begin
      w_biased = w_biased + ((TOTAL_W+1)'(1) << (log2n - 1));
    end
    w_shifted = w_biased >> log2n;
    return w_shifted[ADC_DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_avg_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_result_fifo
// Description : Small synchronous FIFO of averaged results. Drops a push when
//               full unless a pop frees a slot in the same cycle, and reports
//               the drop. When empty the head shows the last popped entry.
// Ports       : clk_clk, reset_reset_n  - clock, async active-low reset
//               clear                   - synchronous flush (pop ignored)
//               push, push_data         - new result
//               pop_ready               - consumer ready
//               head_valid, head_data   - FIFO head (valid = not empty)
//               drop                    - pulse: push discarded (full)
// Revision    : 1.0 - initial release
// ============================================================================
module adc_avg_result_fifo
  import adc_avg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        clear,
  input  logic        push,
  input  adc_result_t push_data,
  input  logic        pop_ready,
  output logic        head_valid,
  output adc_result_t head_data,
  output logic        drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  adc_result_t      r_mem [FIFO_DEPTH];
  adc_result_t      r_last;
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && pop_ready && !clear;
  // A simultaneous pop frees the slot, so a push into a full FIFO survives.
  assign w_push  = push && !clear && (!w_full || w_pop);
  assign drop    = push && !clear && w_full && !w_pop;

  assign head_valid = !w_empty;
  assign head_data  = w_empty ? r_last : r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
        r_wr_ptr                   <= r_wr_ptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr[PTR_W-1:0]];
        r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_channel_averager.sv
`default_nettype none
// ============================================================================
// Module      : adc_channel_averager
// Description : Averages 2^LOG2_AVG ADC samples per tracked channel and
//               streams rounded per-channel averages through a result FIFO.
// Ports       : clk_clk, reset_reset_n      - clock, async active-low reset
//               rsp_valid/channel/data      - ADC sample stream (no stall)
//               rsp_startofpacket/endofpacket - accepted, not used
//               clear                       - synchronous flush
//               avg_valid/ready/channel/data - result stream
//               overflow, err_channel       - sticky status flags
//               drop_count                  - saturating dropped-result count
// Revision    : 1.0 - initial release
// ============================================================================
module adc_channel_averager
  import adc_avg_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CH_BASE    = 1,
  parameter int LOG2_AVG   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  rsp_valid,
  input  logic [ADC_CH_W-1:0]   rsp_channel,
  input  logic [ADC_DATA_W-1:0] rsp_data,
  input  logic                  rsp_startofpacket,
  input  logic                  rsp_endofpacket,
  input  logic                  clear,
  output logic                  avg_valid,
  input  logic                  avg_ready,
  output logic [ADC_CH_W-1:0]   avg_channel,
  output logic [ADC_DATA_W-1:0] avg_data,
  output logic                  overflow,
  output logic                  err_channel,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int SUM_W = ADC_DATA_W + LOG2_AVG;
  // With LOG2_AVG=0 the counter is a single bit pinned at 0, so every
  // sample compares equal to the last count and completes immediately.
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0]    C_CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [ADC_CH_W-1:0] C_CH_BASE  = ADC_CH_W'(CH_BASE);

  logic [SUM_W-1:0] r_sum [NUM_CH];
  logic [CNT_W-1:0] r_cnt [NUM_CH];

  logic                  w_in_range;
  logic                  w_accept;
  logic [ADC_CH_W-1:0]   w_idx;
  logic [SUM_W-1:0]      w_sel_sum;
  logic [CNT_W-1:0]      w_sel_cnt;
  logic                  w_complete;
  logic [SUM_W-1:0]      w_total;
  adc_result_t           w_push_entry;
  logic                  w_push;
  adc_result_t           w_head;
  logic                  w_drop;
  logic                  w_unused_sop_eop;

  assign w_unused_sop_eop = rsp_startofpacket ^ rsp_endofpacket;

  assign w_in_range = (int'(rsp_channel) >= CH_BASE) &&
                      (int'(rsp_channel) <  CH_BASE + NUM_CH);
  assign w_accept   = rsp_valid && w_in_range && !clear;
  assign w_idx      = rsp_channel - C_CH_BASE;

  // Select the addressed channel's running state.
  always_comb begin
    w_sel_sum = '0;
    w_sel_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_idx == ADC_CH_W'(k)) begin
        w_sel_sum = r_sum[k];
        w_sel_cnt = r_cnt[k];
      end
    end
  end

  assign w_complete = (w_sel_cnt == C_CNT_LAST);
  // The sum of 2^LOG2_AVG 12-bit samples always fits in SUM_W bits.
  assign w_total    = w_sel_sum + SUM_W'(rsp_data);

  assign w_push               = w_accept && w_complete;
  assign w_push_entry.channel = rsp_channel;
  assign w_push_entry.data    = round_avg(TOTAL_W'(w_total), LOG2_AVG);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_sum[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else if (clear) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_sum[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_idx == ADC_CH_W'(k)) begin
          if (w_complete) begin
            r_sum[k] <= '0;
            r_cnt[k] <= '0;
          end else begin
            r_sum[k] <= w_total;
            r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overflow    <= 1'b0;
      err_channel <= 1'b0;
      drop_count  <= '0;
    end else if (clear) begin
      overflow    <= 1'b0;
      err_channel <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (rsp_valid && !w_in_range) begin
        err_channel <= 1'b1;
      end
      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_count != {DROP_CNT_W{1'b1}}) begin
          drop_count <= drop_count + DROP_CNT_W'(1);
        end
      end
    end
  end

  adc_avg_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .clear         (clear),
    .push          (w_push),
    .push_data     (w_push_entry),
    .pop_ready     (avg_ready),
    .head_valid    (avg_valid),
    .head_data     (w_head),
    .drop          (w_drop)
  );

  assign avg_channel = w_head.channel;
  assign avg_data    = w_head.data;

endmodule
`default_nettype wire
